// File: rtl/ucsbece154a_mmio_responder.sv
// Memory-mapped output FIFO on the MIPS data-memory port: stores to DATA enqueue words
// for a valid/ready consumer; STAT, CYCLE and DROP are readable through the same window.
module ucsbece154a_mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_i,
    input  logic [31:0] wd_i,
    input  logic        we_i,
    output logic [31:0] rd_o,
    output logic        sel_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OFF_DATA  = 2'd0,
        OFF_STAT  = 2'd1,
        OFF_CYCLE = 2'd2,
        OFF_DROP  = 2'd3
    } off_e;

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] count_q, count_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    off_e        off_c;
    logic        empty_c, full_c;
    logic        push_req_c, push_acc_c, pop_c, drop_c;
    logic        clr_cycle_c, clr_drop_c;
    logic [31:0] head_c;
    logic [1:0]  unused_c;

    assign unused_c    = a_i[1:0];
    assign off_c       = off_e'(a_i[3:2]);
    assign sel_o       = (a_i[31:4] == BASE_ADDR[31:4]);
    assign empty_c     = (count_q == '0);
    assign full_c      = (count_q == FILL_W'(DEPTH));
    assign head_c      = empty_c ? 32'd0 : mem_q[rd_ptr_q];
    assign out_valid_o = ~empty_c;
    assign out_data_o  = head_c;

    // Store decode and FIFO accept; a full FIFO still accepts when the head leaves this cycle
    always_comb begin
        push_req_c  = we_i & sel_o & (off_c == OFF_DATA);
        clr_cycle_c = we_i & sel_o & (off_c == OFF_CYCLE);
        clr_drop_c  = we_i & sel_o & (off_c == OFF_DROP);
        pop_c       = ~empty_c & out_ready_i;
        push_acc_c  = push_req_c & (~full_c | pop_c);
        drop_c      = push_req_c & ~push_acc_c;
    end

    // Next-state for pointers and counters
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cycle_d  = cycle_q + CNT_W'(1);
        drop_d   = drop_q;

        if (push_acc_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_acc_c, pop_c})
            2'b10:   count_d = count_q + FILL_W'(1);
            2'b01:   count_d = count_q - FILL_W'(1);
            default: count_d = count_q;
        endcase

        if (clr_cycle_c) begin
            cycle_d = '0;
        end
        if (clr_drop_c) begin
            drop_d = '0;
        end else if (drop_c && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cycle_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cycle_q  <= cycle_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: entries are only visible between rd and wr pointers
    always_ff @(posedge clk) begin
        if (!reset && push_acc_c) begin
            mem_q[wr_ptr_q] <= wd_i;
        end
    end

    // Combinational load path, matching single-cycle lw timing
    always_comb begin
        rd_o = 32'd0;
        if (sel_o) begin
            case (off_c)
                OFF_DATA:  rd_o = head_c;
                OFF_STAT:  rd_o = {16'd0, 8'(count_q), 6'd0, empty_c, full_c};
                OFF_CYCLE: rd_o = 32'(cycle_q);
                OFF_DROP:  rd_o = 32'(drop_q);
                default:   rd_o = 32'd0;
            endcase
        end
    end

endmodule
